// File: rtl/cla_4bit_pkg.sv
// -----------------------------------------------------------------------------
// cla_4bit_pkg
// Shared definitions for the 4-bit carry-lookahead adder slice.
//   CLA_WIDTH - operand / sum width (fixed at 4)
//   cla_vec_t - 4-bit operand / sum vector type
// -----------------------------------------------------------------------------
package cla_4bit_pkg;

    localparam int CLA_WIDTH = 4;

    typedef logic [CLA_WIDTH-1:0] cla_vec_t;

endpackage : cla_4bit_pkg

// File: rtl/cla_4bit_lookahead.sv
// -----------------------------------------------------------------------------
// cla_lookahead_unit
// Purely combinational 4-bit lookahead unit. Given per-bit (or per-group)
// propagate/generate and a carry-in, it produces every carry directly as a
// two-level sum of products, plus group propagate/generate. The same block
// serves as the second-level unit when four cla_4bit slices are cascaded.
//
// Ports:
//   p[3:0]   in   propagate terms
//   g[3:0]   in   generate terms
//   cin      in   carry into bit 0
//   c[4:1]   out  carries into bits 1..3 and the carry-out (c[4])
//   group_p  out  all four positions propagate
//   group_g  out  the group generates a carry regardless of cin
// -----------------------------------------------------------------------------
module cla_lookahead_unit
    import cla_4bit_pkg::*;
(
    input  cla_vec_t   p,
    input  cla_vec_t   g,
    input  logic       cin,
    output logic [4:1] c,
    output logic       group_p,
    output logic       group_g
);

    // Each carry is written out in full from p/g/cin; no carry term feeds
    // another, so every carry is two gate levels deep.
    always_comb begin
        c[1] = g[0]
             | (p[0] & cin);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & cin);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);

        group_p = p[3] & p[2] & p[1] & p[0];
        group_g = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);
    end

endmodule : cla_lookahead_unit

// File: rtl/cla_4bit.sv
// -----------------------------------------------------------------------------
// cla_4bit
// Four-bit carry-lookahead adder with registered outputs:
// {cout,sum} = in_a + in_b + cin, one cycle after the operands are sampled.
// Group propagate/generate are registered alongside so a higher-level
// lookahead unit can combine several slices.
//
// Interface: no handshake. Inputs are sampled on every rising edge of clk
// (no enable); the outputs always hold the result of the last sampled
// operands. rst is asynchronous and active-high and forces all outputs to 0
// immediately, discarding any pending result.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   in_a     in   operand A (unsigned, 4 bits)
//   in_b     in   operand B (unsigned, 4 bits)
//   cin      in   carry-in
//   sum      out  registered sum bits [3:0]
//   cout     out  registered carry-out (sum bit 4)
//   group_p  out  registered group propagate
//   group_g  out  registered group generate
// -----------------------------------------------------------------------------
module cla_4bit
    import cla_4bit_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  cla_vec_t in_a,
    input  cla_vec_t in_b,
    input  logic     cin,
    output cla_vec_t sum,
    output logic     cout,
    output logic     group_p,
    output logic     group_g
);

    cla_vec_t   w_p;
    cla_vec_t   w_g;
    logic [4:0] w_c;
    cla_vec_t   w_sum;
    logic       w_group_p;
    logic       w_group_g;

    cla_vec_t   r_sum;
    logic       r_cout;
    logic       r_group_p;
    logic       r_group_g;

    assign w_p = in_a ^ in_b;
    assign w_g = in_a & in_b;

    // c[0] is the external carry-in; c[4:1] come straight from the
    // lookahead unit.
    assign w_c[0] = cin;

    cla_lookahead_unit u_lookahead (
        .p       (w_p),
        .g       (w_g),
        .cin     (cin),
        .c       (w_c[4:1]),
        .group_p (w_group_p),
        .group_g (w_group_g)
    );

    assign w_sum = w_p ^ w_c[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_group_p <= 1'b0;
            r_group_g <= 1'b0;
        end else begin
            r_sum     <= w_sum;
            r_cout    <= w_c[4];
            r_group_p <= w_group_p;
            r_group_g <= w_group_g;
        end
    end

    assign sum     = r_sum;
    assign cout    = r_cout;
    assign group_p = r_group_p;
    assign group_g = r_group_g;

endmodule : cla_4bit

// File: tb/tb_cla_4bit.sv
// -----------------------------------------------------------------------------
// tb_cla_4bit
// Self-checking bench for cla_4bit. Inputs are driven on the falling edge,
// the expected {group_p, group_g, cout, sum} is pushed to a queue at the same
// time, and it is popped and compared 1 time unit after the next rising edge.
// -----------------------------------------------------------------------------
module tb_cla_4bit;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       group_p;
    logic       group_g;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    cla_4bit dut (
        .clk     (clk),
        .rst     (rst),
        .in_a    (in_a),
        .in_b    (in_b),
        .cin     (cin),
        .sum     (sum),
        .cout    (cout),
        .group_p (group_p),
        .group_g (group_g)
    );

    // ---------------- scoreboard ----------------
    logic [6:0] exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    // Reference: plain integer addition; group terms from their meaning
    // (all bits propagate / the operands alone overflow 4 bits).
    function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic ci);
        logic [4:0] s;
        logic       gp;
        logic       gg;
        s  = {1'b0, a} + {1'b0, b} + {4'b0, ci};
        gp = ((a ^ b) == 4'hF);
        gg = (({1'b0, a} + {1'b0, b}) > 5'd15);
        return {gp, gg, s[4], s[3:0]};
    endfunction

    function automatic logic [6:0] observed();
        return {group_p, group_g, cout, sum};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed gp,gg,cout,sum=%b expected %b", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci);
        @(negedge clk);
        in_a = a;
        in_b = b;
        cin  = ci;
        exp_q.push_back(model(a, b, ci));
    endtask

    task automatic check_next(input string tag);
        logic [6:0] exp;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, observed %b", tag, observed());
        end else begin
            exp = exp_q.pop_front();
            check(tag, observed(), exp);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst  = 1'b1;
        in_a = 4'd9;
        in_b = 4'd7;
        cin  = 1'b1;

        // Reset held with live operands: outputs stay zero across edges.
        @(posedge clk); #1;
        check("reset_hold_1", observed(), 7'b0);
        @(posedge clk); #1;
        check("reset_hold_2", observed(), 7'b0);

        // Release: first edge captures 9+7+1 = 17.
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(model(4'd9, 4'd7, 1'b1));
        check_next("reset_release_17");
        check("reset_release_17_const", observed(), 7'b0110001);

        // Maximum: 15+15+1 -> cout=1 sum=15, gp=0 gg=1.
        drive(4'd15, 4'd15, 1'b1);
        check_next("max_15_15_1");
        check("max_15_15_1_const", observed(), 7'b0111111);

        // Between edges, input changes must not reach the outputs.
        @(negedge clk);
        in_a = 4'd0;
        in_b = 4'd0;
        cin  = 1'b0;
        #2;
        check("hold_between_edges", observed(), 7'b0111111);
        exp_q.push_back(model(4'd0, 4'd0, 1'b0));
        check_next("zero_0_0_0");

        // Full propagate chain, with and without carry-in.
        drive(4'd15, 4'd0, 1'b1);
        check_next("prop_15_0_1");
        check("prop_15_0_1_const", observed(), 7'b1010000);
        drive(4'd15, 4'd0, 1'b0);
        check_next("prop_15_0_0");
        check("prop_15_0_0_const", observed(), 7'b1001111);

        // No carry anywhere.
        drive(4'd5, 4'd10, 1'b0);
        check_next("nocarry_5_10_0");

        // Mid-operation reset: load a nonzero result first, then pulse rst
        // between edges and check it clears without a clock edge.
        drive(4'd15, 4'd15, 1'b1);
        check_next("pre_midreset");
        @(negedge clk);
        in_a = 4'd3;
        in_b = 4'd4;
        cin  = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midreset_immediate", observed(), 7'b0);
        #1;
        rst = 1'b0;
        exp_q.push_back(model(4'd3, 4'd4, 1'b0));
        check_next("midreset_release_7");

        // Exhaustive sweep: each combination held for two cycles.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    drive(4'(a), 4'(b), 1'(c));
                    check_next($sformatf("sweep_%0d_%0d_%0d", a, b, c));
                    @(posedge clk);
                end
            end
        end

        // A few random spot checks after the sweep.
        for (int i = 0; i < 8; i++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
            check_next($sformatf("random_%0d", i));
        end

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cla_4bit
